// File: rtl/uart_defs_pkg.sv
// rtl/uart_defs_pkg.sv - shared UART receive-path widths, depths and timing constants
package uart_defs;
   localparam int UART_DATA_WIDTH   = 8;
   localparam int UART_FIFO_DEPTH   = 16;
   localparam int UART_CLK_HZ       = 50_000_000;
   localparam int UART_BAUD         = 115_200;
   localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;
endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH register array, one synchronous write port, one asynchronous read port
module fifo_mem
   import uart_defs::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int DEPTH      = UART_FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
)(
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // No reset: contents are only observable through valid pointer ranges.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive byte FIFO with count, full/empty and sticky overflow
// Optional dropped-byte counter output ovf_count enabled by UART_RX_FIFO_OVF_CNT_EN.
module uart_rx_fifo
   import uart_defs::*;
#(
   parameter  int DATA_WIDTH = UART_DATA_WIDTH,
   parameter  int DEPTH      = UART_FIFO_DEPTH,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   input  logic                  overflow_clr
`ifdef UART_RX_FIFO_OVF_CNT_EN
   ,output logic [7:0]           ovf_count
`endif
);
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  ovf_evt;

   assign empty   = (count == '0);
   assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
   assign rd_acc  = rd_en && !empty;
   // A read in the same cycle frees the slot, so a full FIFO can still accept.
   assign wr_acc  = in_valid && (!full || rd_acc);
   assign ovf_evt = in_valid && full && !rd_acc;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc && !reset),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   assign out_data = empty ? '0 : mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ovf_evt) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef UART_RX_FIFO_OVF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_count <= '0;
      end else if (ovf_evt) begin
         if (overflow_clr) begin
            ovf_count <= 8'd1;
         end else if (ovf_count != 8'hFF) begin
            ovf_count <= ovf_count + 8'd1;
         end
      end else if (overflow_clr) begin
         ovf_count <= '0;
      end
   end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with a queue-based reference model
module tb_uart_rx_fifo;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          rd_en = 1'b0;
   logic          overflow_clr = 1'b0;
   logic [DW-1:0] out_data;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          overflow;
`ifdef UART_RX_FIFO_OVF_CNT_EN
   logic [7:0]    ovf_count;
`endif

   int checks = 0;
   int passes = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];
   bit            m_ovf = 1'b0;
   int            m_ovfc = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .rd_en        (rd_en),
      .out_data     (out_data),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
`ifdef UART_RX_FIFO_OVF_CNT_EN
      ,.ovf_count   (ovf_count)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every word the consumer takes must be the oldest accepted byte.
   always @(negedge clk) begin
      if (!reset && rd_en && !empty) begin
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", 1, 0);
         end else begin
            chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic step(input bit iv, input logic [DW-1:0] d, input bit re,
                       input bit clr, input bit rst);
      int  n;
      bit  rd, wr, ev;
      in_valid = iv; in_data = d; rd_en = re; overflow_clr = clr; reset = rst;
      @(negedge clk);
      n = mq.size();
      chk("count", int'(count), n);
      chk("empty", int'(empty), int'(n == 0));
      chk("full", int'(full), int'(n == DEPTH));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (n == 0) chk("out_zero", int'(out_data), 0);
`ifdef UART_RX_FIFO_OVF_CNT_EN
      chk("ovf_count", int'(ovf_count), m_ovfc);
`endif
      @(posedge clk);
      if (rst) begin
         mq.delete(); exp_q.delete(); m_ovf = 0; m_ovfc = 0;
      end else begin
         rd = re && (n > 0);
         wr = iv && ((n < DEPTH) || rd);
         ev = iv && (n == DEPTH) && !rd;
         if (rd) void'(mq.pop_front());
         if (wr) begin mq.push_back(d); exp_q.push_back(d); end
         if (ev) m_ovf = 1;
         else if (clr) m_ovf = 0;
         if (ev) m_ovfc = clr ? 1 : (m_ovfc < 255 ? m_ovfc + 1 : 255);
         else if (clr) m_ovfc = 0;
      end
      #1;
      in_valid = 0; rd_en = 0; overflow_clr = 0; reset = 0;
   endtask

   task automatic wr(input logic [DW-1:0] d); step(1, d, 0, 0, 0); endtask
   task automatic rd(); step(0, '0, 1, 0, 0); endtask
   task automatic idle(); step(0, '0, 0, 0, 0); endtask

   initial begin
      #1;
      step(0, '0, 0, 0, 1);
      idle();
      chk("rst_empty", int'(empty), 1);
      chk("rst_count", int'(count), 0);

      wr(8'h41); wr(8'h42); wr(8'h43);
      chk("t1_count", int'(count), 3);
      chk("t1_head", int'(out_data), 8'h41);
      rd(); chk("t1_pop1", int'(out_data), 8'h42);
      rd(); chk("t1_pop2", int'(out_data), 8'h43);
      rd(); chk("t1_empty", int'(empty), 1);
      chk("t1_zero", int'(out_data), 0);

      for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
      chk("t2_full", int'(full), 1);
      chk("t2_ovf", int'(overflow), 1);
      chk("t2_head", int'(out_data), 8'h10);
      repeat (5) rd();
      step(0, '0, 0, 1, 0);
      chk("t2_clr", int'(overflow), 0);

      for (int i = 0; i < 4; i++) wr(8'h20 + 8'(i));
      step(1, 8'h99, 1, 0, 0);
      chk("t3_count", int'(count), 4);
      chk("t3_ovf", int'(overflow), 0);
      repeat (4) rd();

      step(1, 8'h5A, 1, 0, 0);
      chk("t4_count", int'(count), 1);
      chk("t4_data", int'(out_data), 8'h5A);
      rd(); rd();
      chk("t4_lone", int'(count), 0);

      for (int i = 0; i < 10; i++) begin
         wr(8'(8'hA0 + 8'(i)));
         rd();
      end

      wr(8'h01); wr(8'h02);
      step(1, 8'h03, 0, 0, 1);
      chk("t6_count", int'(count), 0);
      chk("t6_empty", int'(empty), 1);
      chk("t6_zero", int'(out_data), 0);

`ifdef UART_RX_FIFO_OVF_CNT_EN
      for (int i = 0; i < 7; i++) wr(8'h70 + 8'(i));
      chk("t7_cnt3", int'(ovf_count), 3);
      step(0, '0, 0, 1, 0);
      chk("t7_clr", int'(ovf_count), 0);
      repeat (4) rd();
`endif

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 45),
              ($urandom_range(0, 99) < 5), ($urandom_range(0, 199) == 0));
      end
      repeat (DEPTH + 1) rd();
      chk("final_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
